// File: rtl/mbist_pkg.sv
// Shared types for the MBIST read-compare analyzer: background pattern codes,
// the expected byte for each code, and the analyzer FSM state encoding.
package mbist_pkg;

    typedef enum logic [2:0] {
        PAT_AA   = 3'b000,
        PAT_55   = 3'b001,
        PAT_F0   = 3'b010,
        PAT_0F   = 3'b011,
        PAT_00   = 3'b100,
        PAT_FF   = 3'b101,
        PAT_BAD6 = 3'b110,
        PAT_BAD7 = 3'b111
    } pat_code_e;

    localparam logic [7:0] PAT_BYTE_AA = 8'hAA;
    localparam logic [7:0] PAT_BYTE_55 = 8'h55;
    localparam logic [7:0] PAT_BYTE_F0 = 8'hF0;
    localparam logic [7:0] PAT_BYTE_0F = 8'h0F;
    localparam logic [7:0] PAT_BYTE_00 = 8'h00;
    localparam logic [7:0] PAT_BYTE_FF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // Codes 110/111 have no background pattern; a pass with them compares nothing.
    function automatic logic is_bad_code(pat_code_e code);
        return (code == PAT_BAD6) || (code == PAT_BAD7);
    endfunction

endpackage

// File: rtl/mbist_analyzer_decoder.sv
// Pattern-code to expected-byte decoder. Undefined codes decode to 00; the
// analyzer never compares against them.
module mbist_analyzer_decoder
    import mbist_pkg::*;
(
    input  pat_code_e   code,
    output logic [7:0]  exp_data
);

    // Pure lookup of the background byte.
    always_comb begin
        exp_data = PAT_BYTE_00;
        case (code)
            PAT_AA:  exp_data = PAT_BYTE_AA;
            PAT_55:  exp_data = PAT_BYTE_55;
            PAT_F0:  exp_data = PAT_BYTE_F0;
            PAT_0F:  exp_data = PAT_BYTE_0F;
            PAT_00:  exp_data = PAT_BYTE_00;
            PAT_FF:  exp_data = PAT_BYTE_FF;
            default: exp_data = PAT_BYTE_00;
        endcase
    end

endmodule

// File: rtl/mbist_analyzer.sv
// MBIST read-data analyzer. Compares each valid read against the background
// byte of the code latched at start, through a one-stage register pipeline.
// Optional macro MBIST_FAIL_LOG_EN: capture address/data of the first mismatch.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for start; reads ignored, results held
//   ST_COMPARE | pass running; each rd_valid registered, compared next cycle
//   ST_FLUSH   | last read in pipeline; retire it, pulse done, back to idle
module mbist_analyzer
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        q,
    input  logic              rd_valid,
    input  logic              rd_last,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  fail_count,
    output logic              bad_code,
    output logic [ADDR_W-1:0] ff_addr,
    output logic [7:0]        ff_data
);

    state_e             state_q, state_d;
    pat_code_e          code_q, code_d;
    logic               bad_code_q, bad_code_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   fail_count_q, fail_count_d;
    logic               pipe_valid_q, pipe_valid_d;
    logic               pipe_last_q, pipe_last_d;
    logic [7:0]         pipe_data_q, pipe_data_d;
    logic [7:0]         exp_data;
    logic               pass_start;
    logic               mismatch;

    mbist_analyzer_decoder u_decoder (
        .code     (code_q),
        .exp_data (exp_data)
    );

    assign pass_start = (state_q == ST_IDLE) && start;
    assign mismatch   = pipe_valid_q && !bad_code_q && (pipe_data_q != exp_data);

    // Next-state, code latch and read pipeline capture.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        bad_code_d   = bad_code_q;
        done_d       = 1'b0;
        pipe_valid_d = 1'b0;
        pipe_last_d  = 1'b0;
        pipe_data_d  = pipe_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d     = pat_code_e'(q);
                    bad_code_d = is_bad_code(pat_code_e'(q));
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (rd_valid) begin
                    pipe_valid_d = 1'b1;
                    pipe_last_d  = rd_last;
                    pipe_data_d  = rd_data;
                    if (rd_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                done_d  = pipe_last_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mismatch accounting; the counter saturates at all-ones.
    always_comb begin
        fail_d       = fail_q;
        fail_count_d = fail_count_q;
        if (pass_start) begin
            fail_d       = 1'b0;
            fail_count_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (fail_count_q != {CNT_W{1'b1}})
                fail_count_d = fail_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State, pipeline and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= PAT_AA;
            bad_code_q   <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_count_q <= '0;
            pipe_valid_q <= 1'b0;
            pipe_last_q  <= 1'b0;
            pipe_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            bad_code_q   <= bad_code_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_count_q <= fail_count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_last_q  <= pipe_last_d;
            pipe_data_q  <= pipe_data_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_count = fail_count_q;
    assign bad_code   = bad_code_q;

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
    logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
    logic [7:0]        ff_data_q, ff_data_d;

    // First-mismatch capture; fail_q low means no mismatch yet this pass.
    always_comb begin
        pipe_addr_d = pipe_addr_q;
        ff_addr_d   = ff_addr_q;
        ff_data_d   = ff_data_q;
        if ((state_q == ST_COMPARE) && rd_valid) pipe_addr_d = rd_addr;
        if (pass_start) begin
            ff_addr_d = '0;
            ff_data_d = '0;
        end else if (mismatch && !fail_q) begin
            ff_addr_d = pipe_addr_q;
            ff_data_d = pipe_data_q;
        end
    end

    // Capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_addr_q <= '0;
            ff_addr_q   <= '0;
            ff_data_q   <= '0;
        end else begin
            pipe_addr_q <= pipe_addr_d;
            ff_addr_q   <= ff_addr_d;
            ff_data_q   <= ff_data_d;
        end
    end

    assign ff_addr = ff_addr_q;
    assign ff_data = ff_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign ff_addr        = '0;
    assign ff_data        = '0;
`endif

endmodule

// File: tb/tb_mbist_analyzer.sv
// Self-checking bench for mbist_analyzer. Two instances (CNT_W=8 and CNT_W=2)
// share one stimulus; a pass-level model predicts every output every cycle.
module tb_mbist_analyzer;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        q = 3'd0;
    logic              rd_valid = 1'b0;
    logic              rd_last = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data = 8'h00;

    logic              busy, done, fail, bad_code;
    logic [7:0]        fail_count;
    logic [ADDR_W-1:0] ff_addr;
    logic [7:0]        ff_data;

    logic              s_busy, s_done, s_fail, s_bad_code;
    logic [1:0]        s_fail_count;
    logic [ADDR_W-1:0] s_ff_addr;
    logic [7:0]        s_ff_data;

    mbist_analyzer #(.ADDR_W(ADDR_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q(q),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
        .bad_code(bad_code), .ff_addr(ff_addr), .ff_data(ff_data)
    );

    mbist_analyzer #(.ADDR_W(ADDR_W), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .q(q),
        .rd_valid(rd_valid), .rd_last(rd_last), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(s_busy), .done(s_done), .fail(s_fail), .fail_count(s_fail_count),
        .bad_code(s_bad_code), .ff_addr(s_ff_addr), .ff_data(s_ff_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] pat_tab [6] = '{8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h00, 8'hFF};

    // Pass-level model: one pending read, mismatch tally, first failure record.
    bit                m_in_pass = 0, m_last_seen = 0, m_done = 0, m_bad = 0;
    bit                m_pend_v = 0, m_pend_last = 0;
    logic [ADDR_W-1:0] m_pend_addr = '0;
    logic [7:0]        m_pend_data = '0;
    int                m_code = 0;
    int                m_mm = 0;
    logic [ADDR_W-1:0] m_ff_addr = '0;
    logic [7:0]        m_ff_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT will sample.
    task automatic model_step();
        bit was, ls;
        if (!rst_n) begin
            m_in_pass = 0; m_last_seen = 0; m_done = 0; m_bad = 0;
            m_pend_v = 0; m_pend_last = 0; m_code = 0; m_mm = 0;
            m_ff_addr = '0; m_ff_data = '0;
        end else begin
            was = m_in_pass;
            ls  = m_last_seen;
            m_done = 0;
            if (m_pend_v) begin
                if (!m_bad) begin
                    if (m_pend_data != pat_tab[m_code]) begin
                        if (m_mm == 0) begin
                            m_ff_addr = m_pend_addr;
                            m_ff_data = m_pend_data;
                        end
                        if (m_mm < 100000) m_mm++;
                    end
                end
                if (m_pend_last) begin
                    m_done = 1;
                    m_in_pass = 0;
                end
            end
            m_pend_v = was && !ls && rd_valid;
            if (m_pend_v) begin
                m_pend_addr = rd_addr;
                m_pend_data = rd_data;
                m_pend_last = rd_last;
                if (rd_last) m_last_seen = 1;
            end
            if (!was && start) begin
                m_in_pass = 1; m_last_seen = 0;
                m_code = int'(q); m_bad = (q >= 3'd6);
                m_mm = 0; m_ff_addr = '0; m_ff_data = '0;
            end
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_in_pass));
            check("done", 32'(done), 32'(m_done));
            check("fail", 32'(fail), 32'(m_mm > 0));
            check("fail_count", 32'(fail_count), 32'(sat(m_mm, 255)));
            check("bad_code", 32'(bad_code), 32'(m_bad));
`ifdef MBIST_FAIL_LOG_EN
            check("ff_addr", 32'(ff_addr), 32'(m_ff_addr));
            check("ff_data", 32'(ff_data), 32'(m_ff_data));
`else
            check("ff_addr", 32'(ff_addr), 32'd0);
            check("ff_data", 32'(ff_data), 32'd0);
`endif
            check("s_done", 32'(s_done), 32'(m_done));
            check("s_fail", 32'(s_fail), 32'(m_mm > 0));
            check("s_fail_count", 32'(s_fail_count), 32'(sat(m_mm, 3)));
            check("s_busy", 32'(s_busy), 32'(m_in_pass));
            check("s_bad_code", 32'(s_bad_code), 32'(m_bad));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] code);
        start = 1'b1; q = code;
        step();
        start = 1'b0;
    endtask

    task automatic do_read(input int a, input logic [7:0] d, input bit last);
        rd_valid = 1'b1; rd_addr = ADDR_W'(a); rd_data = d; rd_last = last;
        step();
        rd_valid = 1'b0; rd_last = 1'b0;
    endtask

    initial begin
        int dcnt;
        logic [7:0] d;

        rst_n = 1'b0;
        step(); step();
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // All-AA pass, no failures; done one cycle after FLUSH entry.
        do_start(3'b000);
        for (int i = 0; i < 16; i++) do_read(i, 8'hAA, i == 15);
        check("aa_done_early", 32'(done), 32'd0);
        step();
        check("aa_done_timing", 32'(done), 32'd1);
        check("aa_fail", 32'(fail), 32'd0);
        check("aa_count", 32'(fail_count), 32'd0);
        step();
        check("aa_done_single", 32'(done), 32'd0);

        // F0 pass with two mismatches.
        do_start(3'b010);
        for (int i = 0; i < 16; i++) begin
            d = (i == 3) ? 8'hF1 : (i == 9) ? 8'h00 : 8'hF0;
            do_read(i, d, i == 15);
        end
        step();
        check("f0_fail", 32'(fail), 32'd1);
        check("f0_count", 32'(fail_count), 32'd2);
`ifdef MBIST_FAIL_LOG_EN
        check("f0_ff_addr", 32'(ff_addr), 32'h3);
        check("f0_ff_data", 32'(ff_data), 32'hF1);
`else
        check("f0_ff_addr", 32'(ff_addr), 32'h0);
        check("f0_ff_data", 32'(ff_data), 32'h0);
`endif
        step(); step();
        check("f0_hold_count", 32'(fail_count), 32'd2);

        // FF pattern, six zeros: narrow counter saturates.
        do_start(3'b101);
        for (int i = 0; i < 6; i++) do_read(i, 8'h00, i == 5);
        step();
        check("sat_small_count", 32'(s_fail_count), 32'd3);
        check("sat_small_fail", 32'(s_fail), 32'd1);
        check("sat_big_count", 32'(fail_count), 32'd6);

        // Undefined code: no compares, pass still ends once.
        do_start(3'b111);
        check("bad_flag", 32'(bad_code), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 4; i++) do_read(i, 8'hAA, i == 3);
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) dcnt++;
        end
        check("bad_done_pulses", 32'(dcnt), 32'd1);
        check("bad_fail", 32'(fail), 32'd0);
        check("bad_flag_hold", 32'(bad_code), 32'd1);

        // Reset mid-pass after a mismatch: no done, all cleared.
        do_start(3'b001);
        for (int i = 0; i < 5; i++) do_read(i, (i == 2) ? 8'h00 : 8'h55, 1'b0);
        check("rst_pre_fail", 32'(fail), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_count", 32'(fail_count), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) dcnt++;
        end
        check("rst_no_done", 32'(dcnt), 32'd0);

        // start during COMPARE must not change the latched pattern.
        do_start(3'b001);
        for (int i = 0; i < 4; i++) do_read(i, 8'h55, 1'b0);
        start = 1'b1; q = 3'b100;
        do_read(4, 8'h55, 1'b0);
        start = 1'b0;
        for (int i = 5; i < 8; i++) do_read(i, 8'h55, i == 7);
        step();
        check("restart_fail", 32'(fail), 32'd0);
        check("restart_done", 32'(done), 32'd1);

        // Rd_valid in idle must be ignored.
        for (int i = 0; i < 3; i++) do_read(i, 8'h12, 1'b1);
        check("idle_busy", 32'(busy), 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 7) == 0);
            q        = 3'($urandom_range(0, 7));
            rd_valid = ($urandom_range(0, 3) != 0);
            rd_last  = ($urandom_range(0, 11) == 0);
            rd_addr  = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0 || m_code > 5)
                rd_data = 8'($urandom);
            else
                rd_data = pat_tab[m_code];
            step();
        end
        rst_n = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
